// File: rtl/inst_loader.sv
// Boot-time program loader: packs a little-endian byte stream into 32-bit words,
// writes them to instruction memory from address 0 and holds the core until done.
module inst_loader #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   word_count,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] imem_addr,
  output logic [WORD_BITS-1:0] imem_wdata,
  output logic                 imem_we,
  output logic                 core_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [WORD_BITS-1:0] buf_q, buf_d;
  logic                 err_q, err_d;
  logic                 count_ok;
  logic [ADDR_BITS:0]   addr_inc;

  assign count_ok = (word_count != '0) && (word_count <= DEPTH_W);
  // Widened by one bit so a full-depth load ends on the count, not on an address wrap.
  assign addr_inc = {1'b0, addr_q} + (ADDR_BITS+1)'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (count_ok) begin
            cnt_d   = word_count;
            addr_d  = '0;
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          buf_d[{idx_q, 3'b000} +: 8] = in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_inc[ADDR_BITS-1:0];
        idx_d   = '0;
        state_d = (addr_inc == cnt_q) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == S_LOAD);
    imem_we    = (state_q == S_WRITE);
    imem_addr  = addr_q;
    imem_wdata = buf_q;
    busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
    done       = (state_q == S_DONE);
    core_hold  = (state_q != S_DONE);
    error      = err_q;
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a write scoreboard plus done/error/hold
// expectations checked every cycle, and literal checks on the loaded image.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] word_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_we;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  inst_loader #(.ADDR_BITS(10), .DEPTH(1024), .WORD_BITS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  int          nvec = 0;
  int          nerr = 0;
  int          nwrites = 0;
  wr_t         expq[$];
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] mem_seen [0:1023];
  logic [31:0] words [0:1023];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of the load: expected write sequence, done level and error pulse.
  always @(negedge clk) begin
    wr_t e;
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("core_hold", {31'd0, core_hold}, {31'd0, !m_done});
    chk("error", {31'd0, error}, {31'd0, m_err});
    chk("ready_without_busy", {31'd0, in_ready & ~busy}, 32'd0);
    if (imem_we) begin
      if (expq.size() == 0) begin
        chk("spurious_we", {31'd0, imem_we}, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("imem_addr", {22'd0, imem_addr}, {22'd0, e.a});
        chk("imem_wdata", imem_wdata, e.d);
        mem_seen[imem_addr] = imem_wdata;
        nwrites++;
        if (expq.size() == 0) m_done = 1'b1;
      end
    end
  end

  task automatic do_start(input logic [10:0] cnt);
    bit ok;
    ok = (cnt >= 11'd1) && (cnt <= 11'd1024);
    start = 1'b1;
    word_count = cnt;
    @(posedge clk); #1;
    start = 1'b0;
    if (ok) begin
      m_done = 1'b0;
    end else begin
      m_err = 1'b1;
      @(posedge clk); #1;
      m_err = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    chk("byte_accepted", {31'd0, got}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    logic [31:0] tmp;
    tmp = w;
    for (int b = 0; b < 4; b++) begin
      send_byte(tmp[8*b +: 8]);
      if (toggle) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_reached", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input int n, input bit toggle);
    do_start(11'(n));
    for (int i = 0; i < n; i++) expq.push_back({10'(i), words[i]});
    for (int i = 0; i < n; i++) send_word(words[i], toggle);
    wait_done();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_core_hold"}, {31'd0, core_hold}, 32'd1);
    chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    expq.delete();
    m_done = 1'b0;
    m_err = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 1024; i++) mem_seen[i] = 32'hxxxxxxxx;

    // Reset values
    #2;
    check_idle_outputs("por");
    chk("por_imem_addr", {22'd0, imem_addr}, 32'd0);
    chk("por_imem_wdata", imem_wdata, 32'd0);
    chk("por_done", {31'd0, done}, 32'd0);
    chk("por_error", {31'd0, error}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Two-word load, back-to-back bytes
    words[0] = 32'h00000013;
    words[1] = 32'h00100093;
    w0 = nwrites;
    run_load(2, 1'b0);
    chk("t1_writes", 32'(nwrites - w0), 32'd2);
    chk("t1_word0", mem_seen[0], 32'h00000013);
    chk("t1_word1", mem_seen[1], 32'h00100093);

    // Same load with in_valid toggling; start accepted from DONE
    mem_seen[0] = '0;
    mem_seen[1] = '0;
    w0 = nwrites;
    run_load(2, 1'b1);
    chk("t2_writes", 32'(nwrites - w0), 32'd2);
    chk("t2_word0", mem_seen[0], 32'h00000013);
    chk("t2_word1", mem_seen[1], 32'h00100093);

    // Bad counts from IDLE
    do_reset();
    do_start(11'd0);
    do_start(11'd1025);
    check_idle_outputs("t3");

    // start pulsed mid-word-1 is ignored
    words[0] = 32'h11223344;
    words[1] = 32'h55667788;
    words[2] = 32'h99AABBCC;
    w0 = nwrites;
    do_start(11'd3);
    for (int i = 0; i < 3; i++) expq.push_back({10'(i), words[i]});
    send_word(words[0], 1'b0);
    send_byte(8'h88);
    send_byte(8'h77);
    start = 1'b1;
    word_count = 11'd5;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h66);
    send_byte(8'h55);
    send_word(words[2], 1'b0);
    wait_done();
    chk("t4_writes", 32'(nwrites - w0), 32'd3);
    chk("t4_word1", mem_seen[1], 32'h55667788);
    chk("t4_word2", mem_seen[2], 32'h99AABBCC);

    // Reset mid-word-1, then fresh single-word load
    words[0] = 32'h01020304;
    words[1] = 32'h05060708;
    w0 = nwrites;
    do_start(11'd2);
    for (int i = 0; i < 2; i++) expq.push_back({10'(i), words[i]});
    send_word(words[0], 1'b0);
    send_byte(8'h08);
    send_byte(8'h07);
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    chk("t5_writes", 32'(nwrites - w0), 32'd1);
    words[0] = 32'hCAFEBABE;
    run_load(1, 1'b0);
    chk("t5_fresh", mem_seen[0], 32'hCAFEBABE);

    // Full-depth load, word = address
    for (int i = 0; i < 1024; i++) words[i] = 32'(i);
    w0 = nwrites;
    run_load(1024, 1'b0);
    chk("t6_writes", 32'(nwrites - w0), 32'd1024);
    chk("t6_first", mem_seen[0], 32'h00000000);
    chk("t6_last", mem_seen[1023], 32'h000003FF);
    do_start(11'd2047);
    chk("t6_stay_done", {31'd0, done}, 32'd1);
    words[0] = 32'hDEADBEEF;
    run_load(1, 1'b0);
    chk("t6_reload", mem_seen[0], 32'hDEADBEEF);
    chk("t6_kept", mem_seen[1023], 32'h000003FF);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
